// File: rtl/shape_sequencer.sv
// shape_sequencer: walks a shape table once per frame, issuing each valid record to the renderer.
// Optional SHAPE_SEQ_TIMEOUT_EN adds a WAIT watchdog and a sticky timeout_err output.
module shape_sequencer #(
  parameter int CORDW   = 10,
  parameter int DATAW   = 12,
  parameter int NSHAPE  = 8,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic             wr_valid,
  input  logic [DATAW-1:0] wr_ty,
  input  logic [CORDW-1:0] wr_x0,
  input  logic [CORDW-1:0] wr_y0,
  input  logic [DATAW-1:0] wr_size,
  input  logic [IDXW:0]    count,
  input  logic             frame_start,
  input  logic             r_done,
  output logic [DATAW-1:0] ty,
  output logic [CORDW-1:0] x0,
  output logic [CORDW-1:0] y0,
  output logic [DATAW-1:0] size,
  output logic             start,
  output logic [IDXW-1:0]  idx,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
`ifdef SHAPE_SEQ_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, FIN} state_t;
  localparam logic [IDXW:0] NS = NSHAPE[IDXW:0];
  state_t state;
  logic [DATAW-1:0] t_ty [NSHAPE];
  logic [DATAW-1:0] t_size [NSHAPE];
  logic [CORDW-1:0] t_x0 [NSHAPE];
  logic [CORDW-1:0] t_y0 [NSHAPE];
  logic [NSHAPE-1:0] t_valid;
  logic [IDXW:0] idx_r;
  logic [IDXW-1:0] a;
  logic last;
  assign a = idx_r[IDXW-1:0];
  assign idx = a;
  // idx_r is one bit wider than an entry index so the walk can reach NSHAPE without wrapping
  assign last = (idx_r >= count) || (idx_r == NS);
  always_ff @(posedge clk) begin
    if (wr_en) begin
      t_ty[wr_addr] <= wr_ty;
      t_x0[wr_addr] <= wr_x0;
      t_y0[wr_addr] <= wr_y0;
      t_size[wr_addr] <= wr_size;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) t_valid <= '0;
    else if (wr_en) t_valid[wr_addr] <= wr_valid;
  end
`ifdef SHAPE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      start <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      idx_r <= '0;
      ty <= '0;
      x0 <= '0;
      y0 <= '0;
      size <= '0;
`ifdef SHAPE_SEQ_TIMEOUT_EN
      tcnt <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_start) begin
          state <= LOAD;
          idx_r <= '0;
          busy <= 1'b1;
        end
        LOAD: if (last) begin
          state <= FIN;
          frame_done <= 1'b1;
        end else if (!t_valid[a]) begin
          idx_r <= idx_r + 1'b1;
        end else begin
          ty <= t_ty[a];
          x0 <= t_x0[a];
          y0 <= t_y0[a];
          size <= t_size[a];
          start <= 1'b1;
          state <= START;
        end
        START: begin
          state <= WAIT;
`ifdef SHAPE_SEQ_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        WAIT: if (r_done) begin
          idx_r <= idx_r + 1'b1;
          state <= LOAD;
        end
`ifdef SHAPE_SEQ_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          idx_r <= idx_r + 1'b1;
          state <= LOAD;
          timeout_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
`endif
        FIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shape_sequencer.sv
// tb_shape_sequencer: scoreboard bench; a table model predicts the issued records and frame_done per pass.
module tb_shape_sequencer;
  localparam int CORDW = 10, DATAW = 12, NSHAPE = 8, IDXW = 3;
  logic clk = 0, rst = 0, wr_en = 0, wr_valid = 0, frame_start = 0, r_auto = 0, r_man = 0, r_done;
  logic [IDXW-1:0] wr_addr = 0;
  logic [DATAW-1:0] wr_ty = 0, wr_size = 0;
  logic [CORDW-1:0] wr_x0 = 0, wr_y0 = 0;
  logic [IDXW:0] count = 0;
  logic [DATAW-1:0] ty, size;
  logic [CORDW-1:0] x0, y0;
  logic start, busy, frame_done, overrun;
  logic [IDXW-1:0] idx;
  int checks = 0, errors = 0, n_start = 0;
  bit auto_done = 0;
  typedef struct packed {logic fd; logic [31:0] idx, ty, x0, y0, sz;} exp_t;
  exp_t q[$];
  bit mv[NSHAPE];
  int mty[NSHAPE], mx0[NSHAPE], my0[NSHAPE], msz[NSHAPE];

  assign r_done = r_auto | r_man;
  always #5 clk = ~clk;

  shape_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_valid(wr_valid),
    .wr_ty(wr_ty), .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_size(wr_size), .count(count),
    .frame_start(frame_start), .r_done(r_done), .ty(ty), .x0(x0), .y0(y0), .size(size),
    .start(start), .idx(idx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, bit v, int t, int x, int y, int s);
    wr_en = 1; wr_addr = IDXW'(a); wr_valid = v;
    wr_ty = DATAW'(t); wr_x0 = CORDW'(x); wr_y0 = CORDW'(y); wr_size = DATAW'(s);
    tick();
    wr_en = 0;
    mv[a] = v; mty[a] = t; mx0[a] = x; my0[a] = y; msz[a] = s;
  endtask

  // Expected pass: every valid entry below min(count, NSHAPE) in order, then frame_done
  task automatic fs();
    int n;
    n = (int'(count) > NSHAPE) ? NSHAPE : int'(count);
    for (int i = 0; i < n; i++)
      if (mv[i]) q.push_back('{1'b0, 32'(i), 32'(mty[i]), 32'(mx0[i]), 32'(my0[i]), 32'(msz[i])});
    q.push_back('{1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  task automatic wait_fd(int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    chk("frame_done_seen", 32'(seen), 1);
  endtask

  task automatic wait_start(int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1;
    end
    chk("start_seen", 32'(seen), 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (start) begin
        exp_t e;
        n_start++;
        if (q.size() == 0) chk("sb_unexpected_start", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_kind_start", 32'(e.fd), 0);
          chk("sb_idx", 32'(idx), e.idx);
          chk("sb_ty", 32'(ty), e.ty);
          chk("sb_x0", 32'(x0), e.x0);
          chk("sb_y0", 32'(y0), e.y0);
          chk("sb_size", 32'(size), e.sz);
        end
      end
      if (frame_done) begin
        exp_t e;
        if (q.size() == 0) chk("sb_unexpected_frame_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_kind_frame_done", 32'(e.fd), 1);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_done && start && rst) begin
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1 r_auto = 1;
      @(posedge clk);
      #1 r_auto = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_x0", 32'(x0), 0);
    chk("rst_size", 32'(size), 0);
    rst = 1;
    tick();
    // two-entry pass with hand-timed r_done
    wr(0, 1, 0, 10, 20, 16);
    wr(1, 1, 0, 40, 50, 8);
    count = 2;
    fs();
    tick(); @(negedge clk);
    chk("lat_start0", 32'(start), 1);
    chk("lat_x0", 32'(x0), 10);
    chk("lat_y0", 32'(y0), 20);
    chk("lat_size", 32'(size), 16);
    repeat (37) tick();
    @(negedge clk);
    chk("wait_start_low", 32'(start), 0);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_hold_x0", 32'(x0), 10);
    tick(); r_man = 1;
    tick(); r_man = 0;
    @(negedge clk);
    chk("load_start_low", 32'(start), 0);
    tick(); @(negedge clk);
    chk("lat_start1", 32'(start), 1);
    chk("lat1_x0", 32'(x0), 40);
    chk("lat1_y0", 32'(y0), 50);
    chk("lat1_size", 32'(size), 8);
    chk("lat1_idx", 32'(idx), 1);
    repeat (18) tick();
    r_man = 1;
    tick(); r_man = 0;
    tick(); @(negedge clk);
    chk("lat_frame_done", 32'(frame_done), 1);
    chk("fin_busy", 32'(busy), 1);
    tick(); @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_frame_done", 32'(frame_done), 0);
    // invalid entry in the middle costs one LOAD cycle
    wr(1, 0, 7, 7, 7, 7);
    wr(2, 1, 3, 100, 200, 5);
    count = 3;
    n0 = n_start;
    fs();
    tick(); @(negedge clk);
    chk("skip_start0", 32'(start), 1);
    repeat (3) tick();
    r_man = 1;
    tick(); r_man = 0;
    tick(); @(negedge clk);
    chk("skip_extra_load", 32'(start), 0);
    tick(); @(negedge clk);
    chk("skip_start2", 32'(start), 1);
    chk("skip_idx2", 32'(idx), 2);
    repeat (3) tick();
    r_man = 1;
    tick(); r_man = 0;
    wait_fd(20);
    chk("skip_starts", 32'(n_start - n0), 2);
    tick();
    // count = 0
    count = 0;
    fs();
    @(negedge clk);
    chk("c0_busy1", 32'(busy), 1);
    chk("c0_start", 32'(start), 0);
    chk("c0_fd_early", 32'(frame_done), 0);
    tick(); @(negedge clk);
    chk("c0_frame_done", 32'(frame_done), 1);
    chk("c0_busy2", 32'(busy), 1);
    tick(); @(negedge clk);
    chk("c0_busy3", 32'(busy), 0);
    // frame_start while busy
    count = 2;
    fs();
    tick();
    tick();
    frame_start = 1;
    tick();
    frame_start = 0;
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 1);
    repeat (3) tick();
    r_man = 1;
    tick(); r_man = 0;
    wait_fd(20);
    tick(); @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 1);
    chk("overrun_idle", 32'(busy), 0);
    // randomized passes, renderer answers after random delays
    auto_done = 1;
    for (int p = 0; p < 25; p++) begin
      repeat ($urandom_range(0, 4))
        wr($urandom_range(0, NSHAPE - 1), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 4095),
           $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4095));
      count = (IDXW + 1)'($urandom_range(0, 12));
      fs();
      wait_fd(200);
      tick();
      chk("rand_q_empty", 32'(q.size()), 0);
    end
    auto_done = 0;
    repeat (12) tick();
    // async reset while entry 2 is in flight
    for (int i = 0; i < 3; i++) wr(i, 1, i + 1, 10 * i, 20 * i, 5 + i);
    count = 3;
    fs();
    for (int k = 0; k < 2; k++) begin
      wait_start(10);
      tick(); r_man = 1;
      tick(); r_man = 0;
    end
    wait_start(10);
    tick();
    tick();
    #3 rst = 0;
    #1;
    chk("arst_start", 32'(start), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_idx", 32'(idx), 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_q_left", 32'(q.size()), 1);
    q.delete();
    for (int i = 0; i < NSHAPE; i++) mv[i] = 0;
    @(negedge clk);
    rst = 1;
    tick();
    n0 = n_start;
    fs();
    wait_fd(20);
    chk("arst_no_starts", 32'(n_start - n0), 0);
    tick();
    chk("final_q_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
